// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder and its line synchronizer.
package sccb_pkg;

    // Responder transaction state
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDAT,
        ST_WDAT_ACK,
        ST_RDAT,
        ST_RDAT_NA,
        ST_WAIT_STOP
    } sccb_state_t;

    // Each SCCB phase is 8 data bits plus the 9th (ack / don't-care) bit
    localparam int         PHASE_LEN = 9;
    localparam logic [3:0] DATA_BITS = 4'(PHASE_LEN - 1);
    localparam logic [3:0] ACK_BIT   = 4'(PHASE_LEN);

    // LSB of the ID byte selects write (0) or read (1)
    localparam logic ID_WR_LSB = 1'b0;
    localparam logic ID_RD_LSB = 1'b1;

    // Bits fully transferred when a STOP arrives. SIO_C is high at STOP, so the
    // most recent rising edge belongs to the STOP sequence, not to a data bit.
    function automatic logic [3:0] bits_done(input logic [3:0] rise_cnt);
        return (rise_cnt == 4'd0) ? 4'd0 : rise_cnt - 4'd1;
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes raw SIO_C / SIO_D and produces edge and START/STOP pulses.
// All pulses are registered and appear 3 Clk after the pin change.
module sccb_line_sync
    import sccb_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic sioc_in,
    input  logic siod_in,
    output logic sc_rise,
    output logic sc_fall,
    output logic start,
    output logic stop,
    output logic siod_s
);

    logic sc_p0, sc_p1, sc_p2;
    logic sd_p0, sd_p1, sd_p2;

    // 2-FF synchronizers, previous-value stage, and registered event pulses
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sc_p0   <= 1'b1;
            sc_p1   <= 1'b1;
            sc_p2   <= 1'b1;
            sd_p0   <= 1'b1;
            sd_p1   <= 1'b1;
            sd_p2   <= 1'b1;
            sc_rise <= 1'b0;
            sc_fall <= 1'b0;
            start   <= 1'b0;
            stop    <= 1'b0;
        end else begin
            sc_p0   <= sioc_in;
            sc_p1   <= sc_p0;
            sc_p2   <= sc_p1;
            sd_p0   <= siod_in;
            sd_p1   <= sd_p0;
            sd_p2   <= sd_p1;
            sc_rise <= sc_p1 & ~sc_p2;
            sc_fall <= ~sc_p1 & sc_p2;
            start   <= sc_p1 & sc_p2 & ~sd_p1 & sd_p2;
            stop    <= sc_p1 & sc_p2 & sd_p1 & ~sd_p2;
        end
    end

    // Data level aligned with the registered edge pulses
    assign siod_s = sd_p2;

endmodule

// File: rtl/sccb_responder.sv
// SCCB responder modelling the OV7670 register port: 3-phase write,
// 2-phase write (pointer set) and 2-phase read on an inline register file.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID    = 7'h21,
    parameter int         REG_DEPTH = 256
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    input  logic [7:0] obs_addr,
    output logic [7:0] obs_data,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       err
);

    logic        sc_rise, sc_fall, start_p, stop_p, sd_s;
    sccb_state_t state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  rd_sh;
    logic [7:0]  ptr;
    logic [7:0]  regfile [REG_DEPTH];
    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;
    logic        ptr_ok;

    sccb_line_sync u_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .sioc_in (sioc_in),
        .siod_in (siod_in),
        .sc_rise (sc_rise),
        .sc_fall (sc_fall),
        .start   (start_p),
        .stop    (stop_p),
        .siod_s  (sd_s)
    );

    // Byte as it will look once the current bit is shifted in; register lookups
    always_comb begin
        rx_byte  = {shreg[6:0], sd_s};
        ptr_ok   = (32'(ptr) < REG_DEPTH);
        rd_byte  = ptr_ok ? regfile[ptr] : 8'h00;
        obs_data = (32'(obs_addr) < REG_DEPTH) ? regfile[obs_addr] : 8'h00;
    end

    // Transaction FSM with registered bus drive, status pulses and register file
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            rd_sh    <= 8'h00;
            ptr      <= 8'h00;
            siod_oe  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            for (int i = 0; i < REG_DEPTH; i++) begin
                regfile[i] <= 8'h00;
            end
        end else begin
            err      <= 1'b0;
            wr_valid <= 1'b0;
            if (stop_p) begin
                // STOP wins over everything; a partial byte is discarded
                if ((state == ST_ID || state == ST_SUB || state == ST_WDAT || state == ST_RDAT)
                    && (bits_done(bit_cnt) inside {[4'd1:4'd7]})) begin
                    err <= 1'b1;
                end
                state   <= ST_IDLE;
                siod_oe <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_p) begin
                // START or repeated START restarts the ID phase
                state   <= ST_ID;
                siod_oe <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= 4'd0;
            end else if (sc_rise) begin
                case (state)
                    ST_ID, ST_SUB, ST_WDAT: begin
                        if (bit_cnt < DATA_BITS) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == ST_WDAT && bit_cnt == DATA_BITS - 4'd1 && ptr_ok) begin
                                regfile[ptr] <= rx_byte;
                                wr_valid     <= 1'b1;
                                wr_addr      <= ptr;
                                wr_data      <= rx_byte;
                            end
                        end
                    end
                    ST_ID_ACK, ST_SUB_ACK, ST_WDAT_ACK, ST_RDAT: begin
                        if (bit_cnt < ACK_BIT) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_RDAT_NA: begin
                        // master's NA bit is not inspected
                        state <= ST_WAIT_STOP;
                    end
                    default: ;
                endcase
            end else if (sc_fall) begin
                case (state)
                    ST_ID: begin
                        if (bit_cnt == DATA_BITS) begin
                            if (shreg[7:1] == DEV_ID) begin
                                siod_oe <= 1'b1;
                                state   <= ST_ID_ACK;
                            end else begin
                                state   <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_SUB: begin
                        if (bit_cnt == DATA_BITS) begin
                            ptr     <= shreg;
                            siod_oe <= 1'b1;
                            state   <= ST_SUB_ACK;
                        end
                    end
                    ST_WDAT: begin
                        if (bit_cnt == DATA_BITS) begin
                            siod_oe <= 1'b1;
                            state   <= ST_WDAT_ACK;
                        end
                    end
                    ST_ID_ACK: begin
                        if (bit_cnt == ACK_BIT) begin
                            bit_cnt <= 4'd0;
                            if (shreg[0] == ID_RD_LSB) begin
                                // ack release edge also launches the MSB of read data
                                rd_sh   <= rd_byte;
                                siod_oe <= ~rd_byte[7];
                                state   <= ST_RDAT;
                            end else if (shreg[0] == ID_WR_LSB) begin
                                siod_oe <= 1'b0;
                                state   <= ST_SUB;
                            end else begin
                                siod_oe <= 1'b0;
                                state   <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_SUB_ACK: begin
                        if (bit_cnt == ACK_BIT) begin
                            bit_cnt <= 4'd0;
                            siod_oe <= 1'b0;
                            state   <= ST_WDAT;
                        end
                    end
                    ST_WDAT_ACK: begin
                        if (bit_cnt == ACK_BIT) begin
                            siod_oe <= 1'b0;
                            state   <= ST_WAIT_STOP;
                        end
                    end
                    ST_RDAT: begin
                        if (bit_cnt == DATA_BITS) begin
                            siod_oe <= 1'b0;
                            state   <= ST_RDAT_NA;
                        end else begin
                            siod_oe <= ~rd_sh[6];
                            rd_sh   <= {rd_sh[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-banged SCCB master with an open-drain SIO_D model.
module tb_sccb_responder;

    localparam int QC = 4;  // Clk cycles per quarter SIO_C period

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       sioc_in = 1'b1;
    logic       sd_m = 1'b1;
    logic       siod_in;
    logic       siod_oe;
    logic [7:0] obs_addr = 8'h00;
    logic [7:0] obs_data;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       err;

    int          checks = 0;
    int          passes = 0;
    int          err_cnt = 0;
    logic        oe_seen = 1'b0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    assign siod_in = sd_m & ~siod_oe;

    sccb_responder #(.DEV_ID(7'h21), .REG_DEPTH(256)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .sioc_in  (sioc_in),
        .siod_in  (siod_in),
        .siod_oe  (siod_oe),
        .obs_addr (obs_addr),
        .obs_data (obs_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .err      (err)
    );

    always #10 Clk = ~Clk;

    // Monitor: err pulses, any bus drive, and write scoreboard
    always @(negedge Clk) begin
        if (err === 1'b1) err_cnt++;
        if (siod_oe === 1'b1) oe_seen = 1'b1;
        if (wr_valid === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                if ({wr_addr, wr_data} !== e)
                    $display("FAIL wr_pulse: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, e[15:8], e[7:0]);
                else passes++;
            end
        end
    end

    task automatic q();
        repeat (QC) @(negedge Clk);
    endtask

    task automatic start_c();
        sd_m = 1'b1; q();
        sioc_in = 1'b1; q();
        sd_m = 1'b0; q();
        sioc_in = 1'b0; q();
    endtask

    task automatic stop_c();
        sd_m = 1'b0; q();
        sioc_in = 1'b1; q();
        sd_m = 1'b1; q(); q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sd_m = b[7-i]; q();
            sioc_in = 1'b1; q(); q();
            sioc_in = 1'b0; q();
        end
    endtask

    task automatic ack_bit(output logic a);
        sd_m = 1'b1; q();
        sioc_in = 1'b1; q();
        a = siod_oe; q();
        sioc_in = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        send_bits(b, 8);
        ack_bit(a);
    endtask

    task automatic read_byte(output logic [7:0] b, output logic na_oe);
        for (int i = 0; i < 8; i++) begin
            sd_m = 1'b1; q();
            sioc_in = 1'b1; q();
            b[7-i] = siod_in; q();
            sioc_in = 1'b0; q();
        end
        ack_bit(na_oe);
    endtask

    task automatic xact_write3(input logic [7:0] a, input logic [7:0] d, output logic [2:0] acks);
        exp_wr.push_back({a, d});
        start_c();
        write_byte(8'h42, acks[2]);
        write_byte(a, acks[1]);
        write_byte(d, acks[0]);
        stop_c();
    endtask

    task automatic xact_set_ptr(input logic [7:0] a, output logic [1:0] acks);
        start_c();
        write_byte(8'h42, acks[1]);
        write_byte(a, acks[0]);
        stop_c();
    endtask

    task automatic xact_read(output logic [7:0] d, output logic id_ack, output logic na_oe);
        start_c();
        write_byte(8'h43, id_ack);
        read_byte(d, na_oe);
        stop_c();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        obs_addr = 8'h12;
        @(negedge Clk);
        checks++; if (siod_oe !== 1'b0) $display("FAIL reset_oe: got %b, required 0", siod_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b, required 0", err); else passes++;
        checks++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b, required 0", wr_valid); else passes++;
        checks++; if ({wr_addr, wr_data} !== 16'h0000) $display("FAIL reset_wr_regs: got %h, required 0000", {wr_addr, wr_data}); else passes++;
        checks++; if (obs_data !== 8'h00) $display("FAIL reset_regfile: got %h, required 00", obs_data); else passes++;
    endtask

    task automatic test_write3();
        logic [2:0] acks;
        xact_write3(8'h12, 8'h80, acks);
        obs_addr = 8'h12;
        @(negedge Clk);
        checks++; if (acks !== 3'b111) $display("FAIL write3_acks: got %b, required 111", acks); else passes++;
        checks++; if (exp_wr.size() != 0) $display("FAIL write3_wr_pending: got %0d outstanding, required 0", exp_wr.size()); else passes++;
        checks++; if (obs_data !== 8'h80) $display("FAIL write3_obs: got %h, required 80", obs_data); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL write3_busy: got %b, required 0", busy); else passes++;
    endtask

    task automatic test_read();
        logic [1:0] pa;
        logic [2:0] acks;
        logic [7:0] d, e;
        logic       ida, na;
        int         e0;
        e0 = err_cnt;
        xact_set_ptr(8'h3A, pa);
        exp_rd.push_back(8'h00);
        xact_read(d, ida, na);
        e = exp_rd.pop_front();
        checks++; if (pa !== 2'b11) $display("FAIL read_ptr_acks: got %b, required 11", pa); else passes++;
        checks++; if (ida !== 1'b1) $display("FAIL read_id_ack: got %b, required 1", ida); else passes++;
        checks++; if (d !== e) $display("FAIL read_empty: got %h, required %h", d, e); else passes++;
        checks++; if (na !== 1'b0) $display("FAIL read_na_oe: got %b, required 0", na); else passes++;
        checks++; if (err_cnt != e0) $display("FAIL two_phase_err: got %0d pulses, required 0", err_cnt - e0); else passes++;
        xact_write3(8'h3A, 8'h04, acks);
        xact_set_ptr(8'h3A, pa);
        exp_rd.push_back(8'h04);
        xact_read(d, ida, na);
        e = exp_rd.pop_front();
        checks++; if (d !== e) $display("FAIL read_data: got %h, required %h", d, e); else passes++;
        checks++; if (na !== 1'b0) $display("FAIL read2_na_oe: got %b, required 0", na); else passes++;
        checks++; if (exp_wr.size() != 0) $display("FAIL read_wr_pending: got %0d outstanding, required 0", exp_wr.size()); else passes++;
    endtask

    task automatic test_wrong_id();
        logic a0, a1, a2;
        oe_seen = 1'b0;
        start_c();
        write_byte(8'h60, a0);
        write_byte(8'h12, a1);
        write_byte(8'hFF, a2);
        checks++; if (busy !== 1'b1) $display("FAIL wrong_id_busy: got %b, required 1", busy); else passes++;
        stop_c();
        checks++; if ({a0, a1, a2} !== 3'b000) $display("FAIL wrong_id_acks: got %b, required 000", {a0, a1, a2}); else passes++;
        checks++; if (oe_seen !== 1'b0) $display("FAIL wrong_id_oe: got %b, required 0", oe_seen); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL wrong_id_idle: got %b, required 0", busy); else passes++;
        obs_addr = 8'h12;
        @(negedge Clk);
        checks++; if (obs_data !== 8'h80) $display("FAIL wrong_id_regfile: got %h, required 80", obs_data); else passes++;
    endtask

    task automatic test_stop_partial();
        logic       a, ida, na;
        logic [7:0] d, e;
        int         e0;
        e0 = err_cnt;
        start_c();
        write_byte(8'h42, a);
        send_bits(8'h55, 5);
        stop_c();
        checks++; if (err_cnt != e0 + 1) $display("FAIL partial_err: got %0d pulses, required 1", err_cnt - e0); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL partial_idle: got %b, required 0", busy); else passes++;
        exp_rd.push_back(8'h04);
        xact_read(d, ida, na);
        e = exp_rd.pop_front();
        checks++; if (d !== e) $display("FAIL partial_ptr_kept: got %h, required %h", d, e); else passes++;
    endtask

    task automatic test_repeated_start();
        logic [2:0] acks;
        logic       a0, a1, ida, na;
        logic [7:0] d, e;
        xact_write3(8'h1E, 8'h5A, acks);
        xact_set_ptr(8'h01, {a0, a1});
        start_c();
        write_byte(8'h42, a0);
        write_byte(8'h1E, a1);
        exp_rd.push_back(8'h5A);
        start_c();
        write_byte(8'h43, ida);
        read_byte(d, na);
        stop_c();
        e = exp_rd.pop_front();
        checks++; if (d !== e) $display("FAIL rstart_data: got %h, required %h", d, e); else passes++;
        checks++; if (ida !== 1'b1) $display("FAIL rstart_id_ack: got %b, required 1", ida); else passes++;
    endtask

    task automatic test_reset_mid();
        logic       a0, a1, a2;
        logic [2:0] acks;
        int         e0;
        start_c();
        write_byte(8'h42, a0);
        write_byte(8'h12, a1);
        send_bits(8'hFF, 4);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (siod_oe !== 1'b0) $display("FAIL rmid_oe: got %b, required 0", siod_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b, required 0", busy); else passes++;
        obs_addr = 8'h12;
        @(negedge Clk);
        checks++; if (obs_data !== 8'h00) $display("FAIL rmid_regfile: got %h, required 00", obs_data); else passes++;
        e0 = err_cnt;
        send_bits(8'hF0, 4);
        ack_bit(a2);
        stop_c();
        checks++; if (a2 !== 1'b0) $display("FAIL rmid_no_ack: got %b, required 0", a2); else passes++;
        checks++; if (err_cnt != e0) $display("FAIL rmid_idle_stop: got %0d err pulses, required 0", err_cnt - e0); else passes++;
        xact_write3(8'h12, 8'h33, acks);
        obs_addr = 8'h12;
        @(negedge Clk);
        checks++; if (acks !== 3'b111) $display("FAIL rmid_acks: got %b, required 111", acks); else passes++;
        checks++; if (obs_data !== 8'h33) $display("FAIL rmid_write: got %h, required 33", obs_data); else passes++;
        checks++; if (exp_wr.size() != 0) $display("FAIL rmid_wr_pending: got %0d outstanding, required 0", exp_wr.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_write3();
        test_read();
        test_wrong_id();
        test_stop_partial();
        test_repeated_start();
        test_reset_mid();
        repeat (4) @(negedge Clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
